// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: per-cycle shift/rotate/load/clear modes
// plus a counted burst-shift engine with a busy/done handshake.
module universal_shift_register #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [2:0]            mode,
   input  logic                  ser_in_msb,
   input  logic                  ser_in_lsb,
   input  logic [DATA_WIDTH-1:0] par_in,
   input  logic                  start,
   input  logic                  burst_dir,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   output logic [DATA_WIDTH-1:0] par_out,
   output logic                  ser_out_lsb,
   output logic                  ser_out_msb,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHR   = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_ROTR  = 3'b011;
   localparam logic [2:0] MODE_ROTL  = 3'b100;
   localparam logic [2:0] MODE_LOAD  = 3'b101;
   localparam logic [2:0] MODE_CLEAR = 3'b110;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   state_t                  state;
   logic [DATA_WIDTH-1:0]   r;
   logic [LEN_WIDTH-1:0]    count;
   logic                    dir;

   logic [DATA_WIDTH-1:0]   shift_right;
   logic [DATA_WIDTH-1:0]   shift_left;
   logic [DATA_WIDTH-1:0]   rotate_right;
   logic [DATA_WIDTH-1:0]   rotate_left;
   logic [DATA_WIDTH-1:0]   mode_next;
   logic [DATA_WIDTH-1:0]   burst_next;

   always_comb begin
      shift_right  = {ser_in_msb, r[DATA_WIDTH-1:1]};
      shift_left   = {r[DATA_WIDTH-2:0], ser_in_lsb};
      rotate_right = {r[0], r[DATA_WIDTH-1:1]};
      rotate_left  = {r[DATA_WIDTH-2:0], r[DATA_WIDTH-1]};
   end

   // Single-cycle mode decode; the reserved code falls through to hold.
   always_comb begin
      mode_next = r;
      case (mode)
         MODE_HOLD:  mode_next = r;
         MODE_SHR:   mode_next = shift_right;
         MODE_SHL:   mode_next = shift_left;
         MODE_ROTR:  mode_next = rotate_right;
         MODE_ROTL:  mode_next = rotate_left;
         MODE_LOAD:  mode_next = par_in;
         MODE_CLEAR: mode_next = '0;
         default:    mode_next = r;
      endcase
   end

   always_comb begin
      burst_next = dir ? shift_left : shift_right;
   end

   // done defaults low every edge so the pulse lasts one cycle even with en low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         r     <= '0;
         count <= '0;
         dir   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (en) begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (burst_len != '0) begin
                        dir   <= burst_dir;
                        count <= burst_len;
                        busy  <= 1'b1;
                        state <= SHIFT;
                     end else begin
                        done <= 1'b1;
                     end
                  end else begin
                     r <= mode_next;
                  end
               end
               SHIFT: begin
                  r     <= burst_next;
                  count <= count - LEN_ONE;
                  if (count == LEN_ONE) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign par_out     = r;
   assign ser_out_lsb = r[0];
   assign ser_out_msb = r[DATA_WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: a behavioural model feeds an
// expectation queue each cycle, and the outputs are popped and compared after the edge.
module tb_universal_shift_register;

   localparam int W = 8;
   localparam int L = 4;

   logic          clk;
   logic          rst;
   logic          en;
   logic [2:0]    mode;
   logic          ser_in_msb;
   logic          ser_in_lsb;
   logic [W-1:0]  par_in;
   logic          start;
   logic          burst_dir;
   logic [L-1:0]  burst_len;
   logic [W-1:0]  par_out;
   logic          ser_out_lsb;
   logic          ser_out_msb;
   logic          busy;
   logic          done;

   typedef struct {
      logic [W-1:0] r;
      logic         busy;
      logic         done;
      string        tag;
   } expect_t;

   expect_t expQ[$];

   logic [W-1:0] mR;
   logic         mBusy;
   logic         mDone;
   logic         mDir;
   int           mCnt;

   int errCount;
   int checkCount;

   logic serBits[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic expLsb[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   universal_shift_register #(.DATA_WIDTH(W), .LEN_WIDTH(L)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .ser_in_msb  (ser_in_msb),
      .ser_in_lsb  (ser_in_lsb),
      .par_in      (par_in),
      .start       (start),
      .burst_dir   (burst_dir),
      .burst_len   (burst_len),
      .par_out     (par_out),
      .ser_out_lsb (ser_out_lsb),
      .ser_out_msb (ser_out_msb),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic modelReset();
      mR    = '0;
      mBusy = 1'b0;
      mDone = 1'b0;
      mDir  = 1'b0;
      mCnt  = 0;
   endtask

   // Drive one cycle of stimulus, predict the post-edge state, then compare after the edge.
   task automatic applyStimulus(input logic enV, input logic [2:0] modeV, input logic sMsb,
                                input logic sLsb, input logic [W-1:0] pIn, input logic st,
                                input logic bDir, input logic [L-1:0] bLen, input string tag);
      expect_t e;
      en         = enV;
      mode       = modeV;
      ser_in_msb = sMsb;
      ser_in_lsb = sLsb;
      par_in     = pIn;
      start      = st;
      burst_dir  = bDir;
      burst_len  = bLen;
      mDone = 1'b0;
      if (enV) begin
         if (mBusy) begin
            if (mDir) mR = (mR << 1) | {7'd0, sLsb};
            else      mR = (mR >> 1) | {sMsb, 7'd0};
            mCnt = mCnt - 1;
            if (mCnt == 0) begin
               mBusy = 1'b0;
               mDone = 1'b1;
            end
         end else if (st) begin
            if (bLen == 0) begin
               mDone = 1'b1;
            end else begin
               mBusy = 1'b1;
               mDir  = bDir;
               mCnt  = int'(bLen);
            end
         end else begin
            case (modeV)
               3'd1: mR = (mR >> 1) | {sMsb, 7'd0};
               3'd2: mR = (mR << 1) | {7'd0, sLsb};
               3'd3: mR = (mR >> 1) | {mR[0], 7'd0};
               3'd4: mR = (mR << 1) | {7'd0, mR[7]};
               3'd5: mR = pIn;
               3'd6: mR = 8'h00;
               default: ;
            endcase
         end
      end
      e.r = mR;
      e.busy = mBusy;
      e.done = mDone;
      e.tag = tag;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      checkOutput({e.tag, "/par_out"}, 32'(par_out), 32'(e.r));
      checkOutput({e.tag, "/serial"}, 32'({ser_out_msb, ser_out_lsb}), 32'({e.r[7], e.r[0]}));
      checkOutput({e.tag, "/busy"}, 32'(busy), 32'(e.busy));
      checkOutput({e.tag, "/done"}, 32'(done), 32'(e.done));
   endtask

   task automatic doMode(input logic [2:0] m, input logic [W-1:0] pIn, input string tag);
      applyStimulus(1'b1, m, 1'b0, 1'b0, pIn, 1'b0, 1'b0, '0, tag);
   endtask

   task automatic idleCycle(input string tag);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, tag);
   endtask

   // Reset mid-cycle, away from the clock edge, and check the immediate effect.
   task automatic pulseReset(input string tag);
      #3 rst = 1'b1;
      #1;
      checkOutput({tag, "/par_out"}, 32'(par_out), 32'h0);
      checkOutput({tag, "/serial"}, 32'({ser_out_msb, ser_out_lsb}), 32'h0);
      checkOutput({tag, "/busy"}, 32'(busy), 32'h0);
      checkOutput({tag, "/done"}, 32'(done), 32'h0);
      modelReset();
      expQ.delete();
      #1 rst = 1'b0;
   endtask

   initial begin
      int busyCycles;
      int n;
      errCount   = 0;
      checkCount = 0;
      rst = 1'b1;
      en = 1'b0; mode = 3'd0; ser_in_msb = 1'b0; ser_in_lsb = 1'b0;
      par_in = '0; start = 1'b0; burst_dir = 1'b0; burst_len = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("resetPar", 32'(par_out), 32'h0);
      checkOutput("resetBusy", 32'(busy), 32'h0);
      checkOutput("resetDone", 32'(done), 32'h0);

      doMode(3'd5, 8'hFF, "loadFF");
      pulseReset("asyncReset");

      doMode(3'd5, 8'hA5, "loadA5");
      checkOutput("loadA5Const", 32'(par_out), 32'hA5);
      doMode(3'd3, 8'h00, "rotr");
      checkOutput("rotrConst", 32'(par_out), 32'hD2);
      doMode(3'd4, 8'h00, "rotl");
      checkOutput("rotlConst", 32'(par_out), 32'hA5);
      doMode(3'd7, 8'h00, "reserved");
      doMode(3'd0, 8'h00, "hold");
      applyStimulus(1'b1, 3'd2, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0, "shl1");
      applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, "shl0");
      applyStimulus(1'b0, 3'd6, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, "enLowClear");

      doMode(3'd6, 8'h00, "clear");
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 3'd1, serBits[i], 1'b0, '0, 1'b0, 1'b0, '0, $sformatf("shr%0d", i));
      checkOutput("serialIn4D", 32'(par_out), 32'h4D);

      // Burst serialize, with a clear and a second start thrown in while busy.
      doMode(3'd5, 8'h96, "load96");
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd8, "bStart");
      checkOutput("serLsb0", 32'(ser_out_lsb), 32'(expLsb[0]));
      busyCycles = int'(busy);
      for (int i = 1; i < 8; i++) begin
         applyStimulus(1'b1, (i == 3) ? 3'd6 : 3'd0, 1'b0, 1'b1, '0, (i == 4), 1'b1, 4'd3,
                       $sformatf("bShift%0d", i));
         checkOutput($sformatf("serLsb%0d", i), 32'(ser_out_lsb), 32'(expLsb[i]));
         busyCycles += int'(busy);
      end
      idleCycle("bLast");
      checkOutput("bEndPar", 32'(par_out), 32'h0);
      checkOutput("bEndDone", 32'(done), 32'h1);
      checkOutput("bBusyCycles", 32'(busyCycles), 32'd8);

      applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, '0, 1'b1, 1'b1, 4'd1, "b2bStart");
      checkOutput("b2bBusy", 32'(busy), 32'h1);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0, "b2bShift");
      checkOutput("b2bPar", 32'(par_out), 32'h01);

      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd0, "len0");
      checkOutput("len0Done", 32'(done), 32'h1);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, "len0EnLow");

      doMode(3'd5, 8'h3C, "load3C");
      applyStimulus(1'b1, 3'd6, 1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd1, "startClear");
      checkOutput("startWins", 32'(par_out), 32'h3C);
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, "startClearShift");
      checkOutput("startClearPar", 32'(par_out), 32'h9E);

      // Left burst of 3 with two enable-low cycles in the middle.
      doMode(3'd5, 8'h81, "load81");
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 4'd3, "gStart");
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0, "gShift1");
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, "gGap1");
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, "gGap2");
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, "gShift2");
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0, "gShift3");
      checkOutput("gapPar", 32'(par_out), 32'h0D);
      checkOutput("gapDone", 32'(done), 32'h1);

      doMode(3'd5, 8'hF0, "loadF0");
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 4'd5, "rStart");
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, "rShift1");
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, "rShift2");
      pulseReset("midBurstReset");
      idleCycle("postReset");
      doMode(3'd5, 8'h5A, "load5A");
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 4'd2, "r2Start");
      n = 0;
      while (!done && n < 10) begin
         idleCycle($sformatf("r2Wait%0d", n));
         n++;
      end
      checkOutput("r2Edges", 32'(n), 32'd2);
      checkOutput("r2Par", 32'(par_out), 32'h68);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
